// File: rtl/fib_datapath_pkg.sv
// ---------------------------------------------------------------------------
// fib_datapath_pkg
// Shared encodings for the Fibonacci sequencer and its datapath. These are
// the opcodesLOL.v ALU opcodes, the write-back buffer control codes and the
// flag bit positions.
// Contents:
//   OP_*        8-bit ALU operation codes
//   bufCtrl_e   write-back bus source select (4 bits)
//   FLAG_*      bit positions inside the 5-bit {C,L,F,Z,N} flags word
//   isLegalBuf  helper: is a buffCtrl value one of the defined sources
// ---------------------------------------------------------------------------
package fib_datapath_pkg;

    // ALU operation codes
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_CMP = 8'h06;

    // Write-back bus sources
    typedef enum logic [3:0] {
        BUF_ZERO = 4'b0000,
        BUF_IMM  = 4'b0001,
        BUF_ALU  = 4'b1110
    } bufCtrl_e;

    // Flag bit positions within {C,L,F,Z,N}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;
    localparam int NFLAGS = 5;

    function automatic logic isLegalBuf(input logic [3:0] ctrl);
        return (ctrl == BUF_ZERO) || (ctrl == BUF_IMM) || (ctrl == BUF_ALU);
    endfunction

endpackage

// File: rtl/fib_datapath_alu.sv
// ---------------------------------------------------------------------------
// fib_alu
// Purely combinational ALU for the Fibonacci datapath.
// Ports:
//   a, b     in   WIDTH  operands
//   op       in   8      operation code (OP_* from fib_datapath_pkg)
//   result   out  WIDTH  operation result (NOP passes a through)
//   c        out  1      carry-out for ADD, borrow for SUB, else 0
//   l        out  1      a < b, unsigned
//   f        out  1      signed overflow for ADD/SUB, else 0
//   z        out  1      result == 0 (CMP: a == b)
//   n        out  1      result MSB (CMP: a < b signed)
//   opValid  out  1      op is one of the supported codes
// ---------------------------------------------------------------------------
module fib_alu
    import fib_datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             l,
    output logic             f,
    output logic             z,
    output logic             n,
    output logic             opValid
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Both the sum and difference are formed one bit wider so the extra MSB
    // carries the carry-out (ADD) or the borrow (SUB) directly.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        result  = '0;
        c       = 1'b0;
        f       = 1'b0;
        l       = (a < b);
        opValid = 1'b1;

        case (op)
            OP_NOP: result = a;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                f      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                c      = diff[WIDTH];
                f      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_CMP: result = diff[WIDTH-1:0];
            default: opValid = 1'b0;
        endcase

        // Compare reports equality and signed ordering instead of result flags
        z = (result == '0);
        n = result[WIDTH-1];
        if (op == OP_CMP) begin
            z = (a == b);
            n = ($signed(a) < $signed(b));
        end
    end

endmodule

// File: rtl/fib_datapath.sv
// ---------------------------------------------------------------------------
// fib_datapath
// Executes the per-cycle control words from the Fibonacci sequencer: register
// file, ALU, write-back bus mux, flags register and committed-write reporting.
// Ports:
//   clk         in   1          rising-edge clock
//   reset       in   1          asynchronous reset, active low
//   initialR    in   WIDTH      immediate for the write-back bus
//   regWrite    in   4          destination register select
//   regRead1    in   4          ALU operand A select
//   regRead2    in   4          ALU operand B select
//   ALUOp       in   8          ALU operation code
//   buffCtrl    in   4          write-back bus source
//   regWriteEn  in   1          commit the bus to regWrite at the next edge
//   dbgAddr     in   4          debug read select
//   dbgData     out  WIDTH      regfile[dbgAddr], combinational
//   wbValid     out  1          a write committed at the previous edge
//   wbAddr      out  4          destination of the last committed write
//   wbData      out  WIDTH      value of the last committed write
//   flags       out  5          {C,L,F,Z,N}
//   illegal     out  1          sticky: bad buffCtrl/ALUOp seen while enabled
//   writeCount  out  CNT_WIDTH  committed writes since reset, saturating
// ---------------------------------------------------------------------------
module fib_datapath
    import fib_datapath_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NREGS     = 16,
    parameter int CNT_WIDTH = 8,
    localparam int SEL_W    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     initialR,
    input  logic [SEL_W-1:0]     regWrite,
    input  logic [SEL_W-1:0]     regRead1,
    input  logic [SEL_W-1:0]     regRead2,
    input  logic [7:0]           ALUOp,
    input  logic [3:0]           buffCtrl,
    input  logic                 regWriteEn,
    input  logic [SEL_W-1:0]     dbgAddr,
    output logic [WIDTH-1:0]     dbgData,
    output logic                 wbValid,
    output logic [SEL_W-1:0]     wbAddr,
    output logic [WIDTH-1:0]     wbData,
    output logic [NFLAGS-1:0]    flags,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] writeCount
);

    logic [WIDTH-1:0]  regs [NREGS];

    logic [WIDTH-1:0]  aluResult;
    logic              aluC, aluL, aluF, aluZ, aluN, aluOpValid;

    logic [WIDTH-1:0]  bus;
    logic              srcLegal;
    logic              srcAlu;
    logic              isCmp;
    logic              commit;
    logic              flagsLoad;
    logic              illegalNow;
    logic [NFLAGS-1:0] flagsNext;

    // Reads are asynchronous with no bypass; the sequencer registers its
    // control words, so a dependent read one cycle later sees the new value.
    assign dbgData = regs[dbgAddr];

    fib_alu #(.WIDTH(WIDTH)) u_alu (
        .a       (regs[regRead1]),
        .b       (regs[regRead2]),
        .op      (ALUOp),
        .result  (aluResult),
        .c       (aluC),
        .l       (aluL),
        .f       (aluF),
        .z       (aluZ),
        .n       (aluN),
        .opValid (aluOpValid)
    );

    // Bus source selection and the commit/flag/illegal decisions for this
    // cycle. CMP drives the flags but never writes a register; an undefined
    // source or opcode suppresses the write and raises illegal.
    always_comb begin
        bus      = '0;
        srcLegal = 1'b1;
        srcAlu   = 1'b0;
        case (buffCtrl)
            BUF_IMM:  bus = initialR;
            BUF_ALU: begin
                bus    = aluResult;
                srcAlu = 1'b1;
            end
            BUF_ZERO: bus = '0;
            default:  srcLegal = 1'b0;
        endcase

        isCmp      = (ALUOp == OP_CMP);
        commit     = regWriteEn && srcLegal && (!srcAlu || (aluOpValid && !isCmp));
        flagsLoad  = regWriteEn && srcAlu && aluOpValid;
        illegalNow = regWriteEn && (!srcLegal || (srcAlu && !aluOpValid));

        // CMP leaves carry and overflow as they were
        flagsNext          = '0;
        flagsNext[FLAG_C]  = isCmp ? flags[FLAG_C] : aluC;
        flagsNext[FLAG_L]  = aluL;
        flagsNext[FLAG_F]  = isCmp ? flags[FLAG_F] : aluF;
        flagsNext[FLAG_Z]  = aluZ;
        flagsNext[FLAG_N]  = aluN;
    end

    // Register file: every register, R0 included, is ordinary storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[regWrite] <= bus;
        end
    end

    // Commit reporting: wbValid pulses for one cycle after each write while
    // wbAddr/wbData keep the most recent committed write on display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbValid <= 1'b0;
            wbAddr  <= '0;
            wbData  <= '0;
        end else begin
            wbValid <= commit;
            if (commit) begin
                wbAddr <= regWrite;
                wbData <= bus;
            end
        end
    end

    // Flags follow ALU activity only; immediate and zero writes leave them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (flagsLoad) begin
            flags <= flagsNext;
        end
    end

    // Sticky illegal indicator and the saturating committed-write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal    <= 1'b0;
            writeCount <= '0;
        end else begin
            if (illegalNow) begin
                illegal <= 1'b1;
            end
            if (commit && (writeCount != '1)) begin
                writeCount <= writeCount + 1'b1;
            end
        end
    end

endmodule
